// File: rtl/vsram_pkg.sv
// Shared vSRAM definitions: widths, sequencer state encoding, the write
// command carried to the write stage, and the frame-size helper.
package vsram_pkg;

    localparam int VSRAM_DATA_W    = 48;
    localparam int VSRAM_ADDR_W    = 9;
    localparam int VSRAM_NUM_BANKS = 4;
    localparam int VSRAM_BANK_W    = $clog2(VSRAM_NUM_BANKS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } vsram_state_e;

    // One write command; also consumed by the downstream write stage.
    typedef struct packed {
        logic                    we;
        logic [VSRAM_BANK_W-1:0] bank;
        logic [VSRAM_ADDR_W-1:0] col;
        logic [VSRAM_DATA_W-1:0] data;
    } vsram_cmd_t;

    // Words in a frame: (lastCol + 1) columns times the number of banks.
    function automatic logic [VSRAM_ADDR_W+VSRAM_BANK_W:0] frameWords(
        input logic [VSRAM_ADDR_W-1:0] lastCol
    );
        logic [VSRAM_ADDR_W:0] cols;
        cols = {1'b0, lastCol} + (VSRAM_ADDR_W+1)'(1);
        return {cols, {VSRAM_BANK_W{1'b0}}};
    endfunction

endpackage

// File: rtl/vsram_write_sequencer_if.sv
// Bus bundle for the write sequencer: upstream word handshake, issue stall
// and the registered write command towards the vSRAM write stage.
interface vsram_write_sequencer_if #(
    parameter int DATA_W = vsram_pkg::VSRAM_DATA_W,
    parameter int ADDR_W = vsram_pkg::VSRAM_ADDR_W
) ();

    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              in_hold;
    logic              out_writeEnable;
    logic [1:0]        out_vsramNum;
    logic [ADDR_W-1:0] out_colNum;
    logic [DATA_W-1:0] out_dataWriteVal;

    // Upstream producer / environment side.
    modport master (
        output in_valid, in_data, in_hold,
        input  in_ready, out_writeEnable, out_vsramNum, out_colNum, out_dataWriteVal
    );

    // Sequencer side.
    modport slave (
        input  in_valid, in_data, in_hold,
        output in_ready, out_writeEnable, out_vsramNum, out_colNum, out_dataWriteVal
    );

endinterface

// File: rtl/sync_fifo.sv
// Small synchronous FIFO. Flags are registered; a pushed word becomes
// visible at the head one cycle after the push (no fall-through).
module sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 48
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             pushValid,
    input  logic [WIDTH-1:0] pushData,
    input  logic             popValid,
    output logic [WIDTH-1:0] popData,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wrPtr_r;
    logic [PTR_W-1:0] rdPtr_r;
    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] countNext_s;
    logic             full_r;
    logic             empty_r;
    logic             pushEn_s;
    logic             popEn_s;

    assign pushEn_s = pushValid && !full_r;
    assign popEn_s  = popValid && !empty_r;

    // Next occupancy; simultaneous push and pop leaves it unchanged.
    always_comb begin
        countNext_s = count_r;
        case ({pushEn_s, popEn_s})
            2'b10:   countNext_s = count_r + CNT_W'(1);
            2'b01:   countNext_s = count_r - CNT_W'(1);
            default: countNext_s = count_r;
        endcase
    end

    // Pointers, occupancy and registered full/empty flags.
    always_ff @(posedge clock) begin
        if (reset) begin
            wrPtr_r <= '0;
            rdPtr_r <= '0;
            count_r <= '0;
            full_r  <= 1'b0;
            empty_r <= 1'b1;
        end else begin
            if (pushEn_s) wrPtr_r <= wrPtr_r + PTR_W'(1);
            if (popEn_s)  rdPtr_r <= rdPtr_r + PTR_W'(1);
            count_r <= countNext_s;
            full_r  <= (countNext_s == CNT_W'(DEPTH));
            empty_r <= (countNext_s == CNT_W'(0));
        end
    end

    // Storage array; contents need no reset, the flags guard them.
    always_ff @(posedge clock) begin
        if (pushEn_s) mem_r[wrPtr_r] <= pushData;
    end

    assign popData = mem_r[rdPtr_r];
    assign full    = full_r;
    assign empty   = empty_r;

endmodule

// File: rtl/vsram_write_sequencer.sv
// Buffers upstream result words and issues one registered write command per
// cycle, spreading word k over bank k%4, column k/4. Pulses done once the
// frame's last write has reached the SRAM ports of the downstream stage.
module vsram_write_sequencer
    import vsram_pkg::*;
#(
    parameter int DATA_W     = VSRAM_DATA_W,
    parameter int ADDR_W     = VSRAM_ADDR_W,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   in_start,
    input  logic [ADDR_W-1:0]      in_lastCol,
    vsram_write_sequencer_if.slave bus,
    output logic                   busy,
    output logic                   done,
    output logic                   start_err
);

    localparam int ACC_W = ADDR_W + 3;
    localparam int ISS_W = ADDR_W + 2;

    vsram_state_e      state_r;
    vsram_state_e      stateNext_s;
    logic [ADDR_W-1:0] lastCol_r;
    logic [ACC_W-1:0]  acceptCnt_r;
    logic [ACC_W-1:0]  words_s;
    logic [ISS_W-1:0]  issueCnt_r;
    logic              fifoFull_s;
    logic              fifoEmpty_s;
    logic [DATA_W-1:0] fifoData_s;
    logic              startIdle_s;
    logic              inReady_s;
    logic              push_s;
    logic              issue_s;
    logic              lastIssue_s;
    vsram_cmd_t        cmd_r;
    vsram_cmd_t        cmdNext_s;
    logic              busy_r;
    logic              busyNext_s;
    logic              done_r;
    logic              doneNext_s;
    logic              startErr_r;
    logic              startErrNext_s;

    assign words_s     = frameWords(lastCol_r);
    assign startIdle_s = (state_r == IDLE) && in_start;
    assign inReady_s   = (state_r == RUN) && !fifoFull_s && (acceptCnt_r < words_s);
    assign push_s      = bus.in_valid && inReady_s;
    assign issue_s     = (state_r == RUN) && !fifoEmpty_s && !bus.in_hold;
    // The last word's issue index is {lastCol, 2'b11}: bank 3 of the last column.
    assign lastIssue_s = issue_s && (issueCnt_r == {lastCol_r, 2'b11});

    sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_W)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .pushValid (push_s),
        .pushData  (bus.in_data),
        .popValid  (issue_s),
        .popData   (fifoData_s),
        .full      (fifoFull_s),
        .empty     (fifoEmpty_s)
    );

    // FSM state register.
    always_ff @(posedge clock) begin
        if (reset) state_r <= IDLE;
        else       state_r <= stateNext_s;
    end

    // FSM next-state: start only from IDLE, finish on the last issue.
    always_comb begin
        stateNext_s = state_r;
        case (state_r)
            IDLE: begin
                if (in_start) stateNext_s = RUN;
                else          stateNext_s = IDLE;
            end
            RUN: begin
                if (lastIssue_s) stateNext_s = DONE;
                else             stateNext_s = RUN;
            end
            DONE:    stateNext_s = IDLE;
            default: stateNext_s = IDLE;
        endcase
    end

    // Frame length latch plus accept/issue counters, cleared at frame start.
    always_ff @(posedge clock) begin
        if (reset) begin
            lastCol_r   <= '0;
            acceptCnt_r <= '0;
            issueCnt_r  <= '0;
        end else if (startIdle_s) begin
            lastCol_r   <= in_lastCol;
            acceptCnt_r <= '0;
            issueCnt_r  <= '0;
        end else begin
            if (push_s)  acceptCnt_r <= acceptCnt_r + ACC_W'(1);
            if (issue_s) issueCnt_r  <= issueCnt_r + ISS_W'(1);
        end
    end

    // FSM outputs: next write command and status pulses, zeroed when idle.
    always_comb begin
        cmdNext_s = '0;
        if (issue_s) begin
            cmdNext_s.we   = 1'b1;
            cmdNext_s.bank = issueCnt_r[1:0];
            cmdNext_s.col  = issueCnt_r[ISS_W-1:2];
            cmdNext_s.data = fifoData_s;
        end else begin
            cmdNext_s = '0;
        end
        busyNext_s     = (stateNext_s != IDLE);
        // done lands one cycle after the last command, matching the write
        // stage's own register in front of the SRAM enable.
        doneNext_s     = (state_r == DONE);
        startErrNext_s = in_start && (state_r != IDLE);
    end

    // Output register stage.
    always_ff @(posedge clock) begin
        if (reset) begin
            cmd_r      <= '0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            startErr_r <= 1'b0;
        end else begin
            cmd_r      <= cmdNext_s;
            busy_r     <= busyNext_s;
            done_r     <= doneNext_s;
            startErr_r <= startErrNext_s;
        end
    end

    assign bus.in_ready         = inReady_s;
    assign bus.out_writeEnable  = cmd_r.we;
    assign bus.out_vsramNum     = cmd_r.bank;
    assign bus.out_colNum       = cmd_r.col;
    assign bus.out_dataWriteVal = cmd_r.data;
    assign busy                 = busy_r;
    assign done                 = done_r;
    assign start_err            = startErr_r;

endmodule

// File: tb/tb_vsram_write_sequencer.sv
// Directed bench for vsram_write_sequencer: frames of several sizes, issue
// stall, over-supply, start while busy, mid-frame reset and the full range.
module tb_vsram_write_sequencer;
    import vsram_pkg::*;

    typedef struct {
        int          bank;
        int          col;
        logic [47:0] data;
        int          cyc;
    } wr_t;

    logic       clock      = 1'b0;
    logic       reset      = 1'b1;
    logic       in_start   = 1'b0;
    logic [8:0] in_lastCol = 9'd0;
    logic       busy;
    logic       done;
    logic       start_err;

    int  cyc         = 0;
    int  nChecks     = 0;
    int  nPass       = 0;
    int  doneCnt     = 0;
    int  doneCyc     = -1;
    int  startErrCnt = 0;
    int  zeroViol    = 0;
    wr_t wrQ[$];

    vsram_write_sequencer_if bus ();

    vsram_write_sequencer dut (
        .clock      (clock),
        .reset      (reset),
        .in_start   (in_start),
        .in_lastCol (in_lastCol),
        .bus        (bus),
        .busy       (busy),
        .done       (done),
        .start_err  (start_err)
    );

    always #5 clock = ~clock;

    // Cycle counter.
    always @(posedge clock) cyc <= cyc + 1;

    // Write/done/start_err recorder, sampled mid-cycle.
    always @(negedge clock) begin
        if (bus.out_writeEnable === 1'b1)
            wrQ.push_back('{int'(bus.out_vsramNum), int'(bus.out_colNum), bus.out_dataWriteVal, cyc});
        else if ({bus.out_vsramNum, bus.out_colNum, bus.out_dataWriteVal} !== 59'd0)
            zeroViol <= zeroViol + 1;
        if (done === 1'b1) begin
            doneCnt <= doneCnt + 1;
            doneCyc <= cyc;
        end
        if (start_err === 1'b1) startErrCnt <= startErrCnt + 1;
    end

    function automatic logic [47:0] wordOf(input int t, input int k);
        return {16'hDA7A, 8'(t), 24'(k)};
    endfunction

    // Start a frame and feed nSend words; returns when done is seen, when
    // resetAtWrites writes have appeared, or when the cycle budget expires.
    task automatic runFrame(input int t, input logic [8:0] lastCol, input int nSend,
                            input int holdLc, input int holdLen, input int startLc,
                            input int resetAtWrites, input int budget,
                            output int accepted, output int firstAccCyc, output int holdStartCyc,
                            output logic holdEndReady, output logic readyPastLimit,
                            output logic busyAtStart, output logic timedOut);
        int words;
        int baseWr;
        int baseDone;
        words          = (int'(lastCol) + 1) * 4;
        baseWr         = wrQ.size();
        baseDone       = doneCnt;
        accepted       = 0;
        firstAccCyc    = -1;
        holdStartCyc   = -1;
        holdEndReady   = 1'b1;
        readyPastLimit = 1'b0;
        busyAtStart    = 1'b0;
        timedOut       = 1'b1;
        @(posedge clock); #1;
        in_start   = 1'b1;
        in_lastCol = lastCol;
        @(posedge clock); #1;
        for (int lc = 0; lc < budget; lc++) begin
            bus.in_valid = (accepted < nSend);
            bus.in_data  = (accepted < nSend) ? wordOf(t, accepted) : 48'd0;
            bus.in_hold  = (holdLen > 0) && (lc >= holdLc) && (lc < holdLc + holdLen);
            in_start     = (lc == startLc);
            in_lastCol   = (lc == startLc) ? 9'd5 : 9'd0;
            @(negedge clock); #1;
            if (lc == 0) busyAtStart = busy;
            if (holdLen > 0 && lc == holdLc) holdStartCyc = cyc;
            if (holdLen > 0 && lc == holdLc + holdLen - 1) holdEndReady = bus.in_ready;
            if (bus.in_ready && accepted >= words) readyPastLimit = 1'b1;
            if (bus.in_valid && bus.in_ready) begin
                if (accepted == 0) firstAccCyc = cyc;
                accepted++;
            end
            if (doneCnt > baseDone) begin
                timedOut = 1'b0;
                break;
            end
            if (resetAtWrites > 0 && wrQ.size() - baseWr >= resetAtWrites) begin
                timedOut = 1'b0;
                break;
            end
            @(posedge clock); #1;
        end
        bus.in_valid = 1'b0;
        bus.in_data  = 48'd0;
        bus.in_hold  = 1'b0;
        in_start     = 1'b0;
        in_lastCol   = 9'd0;
    endtask

    task automatic test_reset();
        reset        = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data  = 48'd0;
        bus.in_hold  = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        nChecks++;
        if ({bus.in_ready, bus.out_writeEnable, busy, done, start_err} !== 5'b00000)
            $display("FAIL reset_flags: got %b want 00000", {bus.in_ready, bus.out_writeEnable, busy, done, start_err});
        else nPass++;
        nChecks++;
        if ({bus.out_vsramNum, bus.out_colNum, bus.out_dataWriteVal} !== 59'd0)
            $display("FAIL reset_cmd: got %h want 0", {bus.out_vsramNum, bus.out_colNum, bus.out_dataWriteVal});
        else nPass++;
        reset = 1'b0;
        @(posedge clock); #1;
        nChecks++;
        if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else nPass++;
    endtask

    task automatic test_idle_ignore();
        int   baseWr;
        logic sawReady;
        baseWr   = wrQ.size();
        sawReady = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = wordOf(9, i);
            @(negedge clock); #1;
            if (bus.in_ready !== 1'b0) sawReady = 1'b1;
            @(posedge clock); #1;
        end
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        nChecks++;
        if (sawReady !== 1'b0) $display("FAIL idle_ready: got %b want 0", sawReady); else nPass++;
        nChecks++;
        if (wrQ.size() != baseWr) $display("FAIL idle_writes: got %0d want 0", wrQ.size() - baseWr); else nPass++;
    endtask

    task automatic test_single_column();
        int acc, fa, hs, baseWr, baseDone, nWr;
        logic hr, pl, bs, to;
        baseWr = wrQ.size(); baseDone = doneCnt;
        runFrame(1, 9'd0, 4, 0, 0, -1, 0, 40, acc, fa, hs, hr, pl, bs, to);
        nWr = wrQ.size() - baseWr;
        nChecks++; if (to !== 1'b0) $display("FAIL t1_timeout: got %b want 0", to); else nPass++;
        nChecks++; if (bs !== 1'b1) $display("FAIL t1_busy: got %b want 1", bs); else nPass++;
        nChecks++; if (nWr != 4) $display("FAIL t1_count: got %0d want 4", nWr); else nPass++;
        for (int k = 0; k < nWr && k < 4; k++) begin
            nChecks++;
            if (wrQ[baseWr+k].bank != k || wrQ[baseWr+k].col != 0 || wrQ[baseWr+k].data !== wordOf(1, k))
                $display("FAIL t1_slot%0d: got b%0d c%0d %h want b%0d c0 %h", k, wrQ[baseWr+k].bank,
                         wrQ[baseWr+k].col, wrQ[baseWr+k].data, k, wordOf(1, k));
            else nPass++;
            nChecks++;
            if (wrQ[baseWr+k].cyc != fa + 2 + k)
                $display("FAIL t1_time%0d: got cycle %0d want %0d", k, wrQ[baseWr+k].cyc, fa + 2 + k);
            else nPass++;
        end
        nChecks++; if (doneCnt - baseDone != 1) $display("FAIL t1_done_cnt: got %0d want 1", doneCnt - baseDone); else nPass++;
        if (nWr == 4) begin
            nChecks++;
            if (doneCyc != wrQ[baseWr+3].cyc + 1)
                $display("FAIL t1_done_time: got cycle %0d want %0d", doneCyc, wrQ[baseWr+3].cyc + 1);
            else nPass++;
        end
        nChecks++; if (busy !== 1'b0) $display("FAIL t1_busy_end: got %b want 0", busy); else nPass++;
    endtask

    task automatic test_hold();
        int acc, fa, hs, baseWr, baseDone, nWr, errs, inWin;
        logic hr, pl, bs, to;
        baseWr = wrQ.size(); baseDone = doneCnt;
        runFrame(2, 9'd2, 12, 4, 5, -1, 0, 80, acc, fa, hs, hr, pl, bs, to);
        nWr = wrQ.size() - baseWr;
        errs = 0; inWin = 0;
        for (int k = 0; k < nWr; k++) begin
            if (wrQ[baseWr+k].bank != k % 4 || wrQ[baseWr+k].col != k / 4 || wrQ[baseWr+k].data !== wordOf(2, k)) errs++;
            if (wrQ[baseWr+k].cyc >= hs + 1 && wrQ[baseWr+k].cyc <= hs + 5) inWin++;
        end
        nChecks++; if (to !== 1'b0) $display("FAIL t2_timeout: got %b want 0", to); else nPass++;
        nChecks++; if (hr !== 1'b0) $display("FAIL t2_ready_full: got %b want 0", hr); else nPass++;
        nChecks++; if (inWin != 0) $display("FAIL t2_hold_writes: got %0d want 0", inWin); else nPass++;
        nChecks++; if (nWr != 12) $display("FAIL t2_count: got %0d want 12", nWr); else nPass++;
        nChecks++; if (errs != 0) $display("FAIL t2_order: got %0d bad writes want 0", errs); else nPass++;
        if (nWr > 9) begin
            nChecks++;
            if (wrQ[baseWr+9].bank != 1 || wrQ[baseWr+9].col != 2)
                $display("FAIL t2_word9: got b%0d c%0d want b1 c2", wrQ[baseWr+9].bank, wrQ[baseWr+9].col);
            else nPass++;
        end
        nChecks++; if (doneCnt - baseDone != 1) $display("FAIL t2_done_cnt: got %0d want 1", doneCnt - baseDone); else nPass++;
    endtask

    task automatic test_oversupply();
        int acc, fa, hs, baseWr, baseDone, nWr, errs;
        logic hr, pl, bs, to;
        baseWr = wrQ.size(); baseDone = doneCnt;
        runFrame(3, 9'd2, 14, 0, 0, -1, 0, 80, acc, fa, hs, hr, pl, bs, to);
        nWr = wrQ.size() - baseWr;
        errs = 0;
        for (int k = 0; k < nWr; k++)
            if (wrQ[baseWr+k].data !== wordOf(3, k)) errs++;
        nChecks++; if (acc != 12) $display("FAIL t3_accepted: got %0d want 12", acc); else nPass++;
        nChecks++; if (pl !== 1'b0) $display("FAIL t3_ready_after_12: got %b want 0", pl); else nPass++;
        nChecks++; if (nWr != 12) $display("FAIL t3_count: got %0d want 12", nWr); else nPass++;
        nChecks++; if (errs != 0) $display("FAIL t3_data: got %0d bad writes want 0", errs); else nPass++;
        nChecks++; if (doneCnt - baseDone != 1) $display("FAIL t3_done_cnt: got %0d want 1", doneCnt - baseDone); else nPass++;
    endtask

    task automatic test_start_err();
        int acc, fa, hs, baseWr, baseDone, baseErr, nWr, errs;
        logic hr, pl, bs, to;
        baseWr = wrQ.size(); baseDone = doneCnt; baseErr = startErrCnt;
        runFrame(4, 9'd1, 8, 0, 0, 3, 0, 60, acc, fa, hs, hr, pl, bs, to);
        nWr = wrQ.size() - baseWr;
        errs = 0;
        for (int k = 0; k < nWr; k++)
            if (wrQ[baseWr+k].bank != k % 4 || wrQ[baseWr+k].col != k / 4 || wrQ[baseWr+k].data !== wordOf(4, k)) errs++;
        nChecks++; if (startErrCnt - baseErr != 1) $display("FAIL t4_start_err: got %0d cycles want 1", startErrCnt - baseErr); else nPass++;
        nChecks++; if (nWr != 8) $display("FAIL t4_count: got %0d want 8", nWr); else nPass++;
        nChecks++; if (errs != 0) $display("FAIL t4_order: got %0d bad writes want 0", errs); else nPass++;
        nChecks++; if (doneCnt - baseDone != 1) $display("FAIL t4_done_cnt: got %0d want 1", doneCnt - baseDone); else nPass++;
    endtask

    task automatic test_reset_mid_frame();
        int acc, fa, hs, baseWr, baseDone, nWr, afterWr;
        logic hr, pl, bs, to;
        baseDone = doneCnt;
        runFrame(5, 9'd1, 8, 0, 0, -1, 5, 60, acc, fa, hs, hr, pl, bs, to);
        nChecks++; if (to !== 1'b0) $display("FAIL t5_reach5: got timeout %b want 0", to); else nPass++;
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        nChecks++;
        if ({bus.in_ready, bus.out_writeEnable, busy, done, start_err} !== 5'b00000 ||
            {bus.out_vsramNum, bus.out_colNum, bus.out_dataWriteVal} !== 59'd0)
            $display("FAIL t5_outputs: got flags %b cmd %h want all 0",
                     {bus.in_ready, bus.out_writeEnable, busy, done, start_err},
                     {bus.out_vsramNum, bus.out_colNum, bus.out_dataWriteVal});
        else nPass++;
        afterWr = wrQ.size();
        repeat (8) @(posedge clock);
        #1;
        nChecks++; if (wrQ.size() != afterWr) $display("FAIL t5_no_writes: got %0d want 0", wrQ.size() - afterWr); else nPass++;
        nChecks++; if (doneCnt != baseDone) $display("FAIL t5_no_done: got %0d want 0", doneCnt - baseDone); else nPass++;
        baseWr = wrQ.size();
        runFrame(7, 9'd0, 4, 0, 0, -1, 0, 40, acc, fa, hs, hr, pl, bs, to);
        nWr = wrQ.size() - baseWr;
        nChecks++; if (nWr != 4) $display("FAIL t5_new_count: got %0d want 4", nWr); else nPass++;
        if (nWr > 0) begin
            nChecks++;
            if (wrQ[baseWr].bank != 0 || wrQ[baseWr].col != 0 || wrQ[baseWr].data !== wordOf(7, 0))
                $display("FAIL t5_new_first: got b%0d c%0d %h want b0 c0 %h", wrQ[baseWr].bank,
                         wrQ[baseWr].col, wrQ[baseWr].data, wordOf(7, 0));
            else nPass++;
        end
    endtask

    task automatic test_full_range();
        int acc, fa, hs, baseWr, baseDone, nWr, errs;
        logic hr, pl, bs, to;
        baseWr = wrQ.size(); baseDone = doneCnt;
        runFrame(6, 9'd511, 2048, 0, 0, -1, 0, 2300, acc, fa, hs, hr, pl, bs, to);
        nWr = wrQ.size() - baseWr;
        errs = 0;
        for (int k = 0; k < nWr; k++)
            if (wrQ[baseWr+k].bank != k % 4 || wrQ[baseWr+k].col != k / 4 || wrQ[baseWr+k].data !== wordOf(6, k)) errs++;
        nChecks++; if (to !== 1'b0) $display("FAIL t6_timeout: got %b want 0", to); else nPass++;
        nChecks++; if (nWr != 2048) $display("FAIL t6_count: got %0d want 2048", nWr); else nPass++;
        nChecks++; if (errs != 0) $display("FAIL t6_order: got %0d bad writes want 0", errs); else nPass++;
        if (nWr > 0) begin
            nChecks++;
            if (wrQ[wrQ.size()-1].bank != 3 || wrQ[wrQ.size()-1].col != 511)
                $display("FAIL t6_last: got b%0d c%0d want b3 c511", wrQ[wrQ.size()-1].bank, wrQ[wrQ.size()-1].col);
            else nPass++;
        end
        nChecks++; if (doneCnt - baseDone != 1) $display("FAIL t6_done_cnt: got %0d want 1", doneCnt - baseDone); else nPass++;
    endtask

    task automatic test_idle_outputs();
        nChecks++;
        if (zeroViol != 0) $display("FAIL idle_cmd_zero: got %0d nonzero idle cycles want 0", zeroViol);
        else nPass++;
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = 48'd0;
        bus.in_hold  = 1'b0;
        test_reset();
        test_idle_ignore();
        test_single_column();
        test_hold();
        test_oversupply();
        test_start_err();
        test_reset_mid_frame();
        test_full_range();
        test_idle_outputs();
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
